noc_packet_receiver: RTL
========================

Name: noc_packet_receiver

Overview:
- Destination-side network interface at a NoC node output port. Sinks the Node<k>_data_out / valid_out / ready_out flit stream, checks head/body/tail sequencing and routing, and buffers one packet's payload.
- Replays the payload to the local consumer as a word stream with a last marker.
- Keeps saturating packet and error counters for bench and debug visibility.

Parameters:
- N, 6, number of nodes; destination field width DW = clog2(N).
- INDEX, 0, this node's ID, compared against the head-flit destination.
- DATA_WIDTH, 32, flit width.
- TYPE_WIDTH, 2, flit type field at [DATA_WIDTH-1 -: TYPE_WIDTH].
- FlitPerPacket, 6, head + (FlitPerPacket-2) body + tail.
- PW, FlitPerPacket-1, payload words per packet (body and tail flits carry data).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  flit from the NoC node output.
- valid_in  in  1  flit valid.
- ready_in  out  1  receiver can accept a flit.
- pl_data  out  DATA_WIDTH-TYPE_WIDTH  payload word (type bits stripped).
- pl_valid  out  1  payload word valid.
- pl_ready  in  1  consumer accepts the word.
- pl_last  out  1  final word of the packet.
- pl_dest  out  DW  destination field of the buffered head.
- err_pulse  out  1  one-cycle pulse per detected protocol error.
- pkt_count  out  16  packets fully delivered, saturating.
- err_count  out  16  errors detected, saturating.

Behaviour:
- Flit transfer occurs when valid_in && ready_in at posedge clk. Payload transfer occurs when pl_valid && pl_ready.
- Flit types: 1 = HEAD, 2 = BODY, 3 = TAIL, 0 = invalid. The HEAD destination is data_in[DW-1:0].
- Reset: state IDLE. All outputs 0: ready_in, pl_valid, pl_last, pl_data, pl_dest, err_pulse, pkt_count, err_count. Buffer contents are don't-care. ready_in goes to 1 the first cycle after rst deasserts.
- rst asserted mid-packet or mid-drain discards everything. No counter update occurs for the aborted packet.
- States:
  - IDLE: ready_in = 1. On HEAD with dest == INDEX, latch pl_dest, clear wr_ptr, go to COLLECT. On HEAD with dest != INDEX: error, go to SKIP. On BODY, TAIL or type 0: discard, error, stay in IDLE.
  - COLLECT: ready_in = 1.
    - BODY with wr_ptr < PW-1: store word, wr_ptr++.
    - BODY with wr_ptr == PW-1 (excess body): error, go to SKIP.
    - TAIL with wr_ptr == PW-1: store word, go to DRAIN.
    - TAIL with wr_ptr < PW-1 (early tail): error, drop packet, go to IDLE.
    - HEAD (head inside a packet): error, drop the partial packet, then treat the flit as a fresh IDLE head in the same cycle.
    - Type 0: error, drop packet, go to SKIP.
  - SKIP: ready_in = 1. Accept and discard flits until a TAIL, then go to IDLE. No further errors are counted while in SKIP.
  - DRAIN: ready_in = 0.
    - pl_valid = 1 and pl_data = buf[rd_ptr], with rd_ptr starting at 0.
    - pl_last = (rd_ptr == PW-1).
    - Each payload handshake increments rd_ptr.
    - On the handshake of the last word: pkt_count++, go to IDLE.
- Latency: TAIL accepted at edge k gives pl_valid = 1 in the cycle after edge k. The last payload handshake at edge m gives ready_in = 1 in the cycle after edge m.
- pl_data, pl_last and pl_dest hold stable while pl_valid && !pl_ready.
- err_pulse is high for exactly the cycle after the offending flit's edge. err_count increments by exactly 1 per error.
- Both counters saturate at 16'hFFFF and do not wrap.
- ready_in is a registered function of state only. It never depends combinationally on valid_in.

Test Plan:
- Nominal, INDEX = 5:
  - Stimulus: flits 0x40000005, 0x80000012, 0x80000013, 0x80000014, 0x80000015, 0xC0000016.
  - Required: pl_data = 0x12..0x16 in order, pl_last only on 0x16, pl_dest = 5, pkt_count = 1, err_count = 0.
- Backpressure:
  - Stimulus: same packet as nominal, with pl_ready low for 3 cycles on every word.
  - Required: each word holds stable, no loss or duplication, ready_in = 0 throughout DRAIN, a second back-to-back packet is accepted only after the last handshake, pkt_count = 2.
- Misroute:
  - Stimulus: INDEX = 5, packet with head 0x40000004.
  - Required: all 6 flits accepted, pl_valid never asserted, err_count = 1, one err_pulse.
- Stray and early tail:
  - Stimulus: BODY 0x80000001 while in IDLE.
  - Required: err_count = 1.
  - Stimulus: head 0x40000005, BODY 0x80000012, then TAIL 0xC0000013.
  - Required: err_count = 2, no payload output, next valid packet delivered correctly.
- Reset mid-packet:
  - Stimulus: assert rst after 3 flits of a valid packet, then send a full packet.
  - Required: outputs and counters are 0 during reset, only the second packet is delivered, pkt_count = 1.
- Counter saturation:
  - Stimulus: force err_count to 16'hFFFF, then send a stray BODY.
  - Required: err_count stays at 16'hFFFF, err_pulse still fires.

Source files
------------

// File: rtl/noc_packet_receiver.sv
// Destination-side NoC network interface.
// Sinks the head/body/tail flit stream of one router output port, checks the
// flit sequence and the routing, buffers a single packet's payload and then
// replays it to the local consumer as a word stream with a last marker.
// Saturating packet and error counters are exposed for debug.
module noc_packet_receiver #(
    parameter int N             = 6,
    parameter int INDEX         = 0,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int FlitPerPacket = 6,
    localparam int DW           = $clog2(N),
    localparam int PW           = FlitPerPacket - 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic                           valid_in,
    output logic                           ready_in,
    output logic [DATA_WIDTH-TYPE_WIDTH-1:0] pl_data,
    output logic                           pl_valid,
    input  logic                           pl_ready,
    output logic                           pl_last,
    output logic [DW-1:0]                  pl_dest,
    output logic                           err_pulse,
    output logic [15:0]                    pkt_count,
    output logic [15:0]                    err_count
);

    localparam int PLW   = DATA_WIDTH - TYPE_WIDTH;
    localparam int PTR_W = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(PW - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_SKIP    = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    localparam logic [TYPE_WIDTH-1:0] T_HEAD = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] T_BODY = TYPE_WIDTH'(2);
    localparam logic [TYPE_WIDTH-1:0] T_TAIL = TYPE_WIDTH'(3);

    logic [1:0]             r_state;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic                   r_ready;
    logic                   r_pl_valid;
    logic                   r_pl_last;
    logic [PLW-1:0]         r_pl_data;
    logic [DW-1:0]          r_pl_dest;
    logic                   r_err_pulse;
    logic [PLW-1:0]         r_mem [PW];

    logic [TYPE_WIDTH-1:0]  w_type;
    logic                   w_dest_hit;
    logic                   w_flit_acc;
    logic                   w_pl_hs;
    logic [1:0]             w_state_next;
    logic [PTR_W-1:0]       w_wr_ptr_next;
    logic [PTR_W-1:0]       w_rd_ptr_next;
    logic                   w_wr_en;
    logic [PLW-1:0]         w_wr_data;
    logic                   w_latch_dest;
    logic                   w_err;
    logic                   w_pkt_done;
    logic [PLW-1:0]         w_rd_word;
    logic [1:0]             w_cnt_inc;

    assign w_type     = data_in[DATA_WIDTH-1 -: TYPE_WIDTH];
    assign w_dest_hit = (data_in[DW-1:0] == DW'(INDEX));
    assign w_flit_acc = valid_in && r_ready;
    assign w_pl_hs    = r_pl_valid && pl_ready;
    assign w_wr_data  = data_in[PLW-1:0];

    // Next-state, buffer write and error detection for the flit/payload handshakes
    always_comb begin
        w_state_next  = r_state;
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_wr_en       = 1'b0;
        w_latch_dest  = 1'b0;
        w_err         = 1'b0;
        w_pkt_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_flit_acc) begin
                    if (w_type == T_HEAD) begin
                        if (w_dest_hit) begin
                            w_latch_dest  = 1'b1;
                            w_wr_ptr_next = '0;
                            w_state_next  = S_COLLECT;
                        end else begin
                            w_err        = 1'b1;
                            w_state_next = S_SKIP;
                        end
                    end else begin
                        // stray body/tail/invalid flit: dropped where it lands
                        w_err = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (w_flit_acc) begin
                    if (w_type == T_BODY) begin
                        if (r_wr_ptr != LAST_PTR) begin
                            w_wr_en       = 1'b1;
                            w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
                        end else begin
                            w_err        = 1'b1;
                            w_state_next = S_SKIP;
                        end
                    end else if (w_type == T_TAIL) begin
                        if (r_wr_ptr == LAST_PTR) begin
                            w_wr_en       = 1'b1;
                            w_rd_ptr_next = '0;
                            w_state_next  = S_DRAIN;
                        end else begin
                            w_err        = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end else if (w_type == T_HEAD) begin
                        // partial packet is abandoned; the new head is handled
                        // exactly like a head arriving in IDLE (one error total)
                        w_err = 1'b1;
                        if (w_dest_hit) begin
                            w_latch_dest  = 1'b1;
                            w_wr_ptr_next = '0;
                            w_state_next  = S_COLLECT;
                        end else begin
                            w_state_next = S_SKIP;
                        end
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = S_SKIP;
                    end
                end
            end
            S_SKIP: begin
                if (w_flit_acc && (w_type == T_TAIL)) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_pl_hs) begin
                    if (r_rd_ptr == LAST_PTR) begin
                        w_pkt_done    = 1'b1;
                        w_rd_ptr_next = '0;
                        w_state_next  = S_IDLE;
                    end else begin
                        w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Payload buffer write port (contents need no reset)
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // Forward the tail word when it is written and read in the same cycle (single-word packets)
    assign w_rd_word = (w_wr_en && (r_wr_ptr == w_rd_ptr_next)) ? w_wr_data : r_mem[w_rd_ptr_next];

    // Registered buffer read: pl_data is refreshed only while draining so it holds under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pl_data <= '0;
        end else if (w_state_next == S_DRAIN) begin
            r_pl_data <= w_rd_word;
        end
    end

    // Control state and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ready     <= 1'b0;
            r_pl_valid  <= 1'b0;
            r_pl_last   <= 1'b0;
            r_pl_dest   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_ready     <= (w_state_next != S_DRAIN);
            r_pl_valid  <= (w_state_next == S_DRAIN);
            r_pl_last   <= (w_state_next == S_DRAIN) && (w_rd_ptr_next == LAST_PTR);
            r_err_pulse <= w_err;
            if (w_latch_dest) begin
                r_pl_dest <= data_in[DW-1:0];
            end
        end
    end

    // Saturating event counters: index 0 counts delivered packets, index 1 counts errors
    assign w_cnt_inc = {w_err, w_pkt_done};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [15:0] r_cnt;
            // Increment on the event unless already pinned at the maximum
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    endgenerate

    assign ready_in  = r_ready;
    assign pl_valid  = r_pl_valid;
    assign pl_last   = r_pl_last;
    assign pl_data   = r_pl_data;
    assign pl_dest   = r_pl_dest;
    assign err_pulse = r_err_pulse;
    assign pkt_count = g_cnt[0].r_cnt;
    assign err_count = g_cnt[1].r_cnt;

endmodule
